// File: rtl/ebpc_zrle_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ebpc_zrle_stream_encoder
// Description : Word-level zero-run-length encoder for the EBPC datapath.
//               Turns an input word stream into tokens {is_run, payload}:
//               non-zero words become literals {0, word}, runs of zeros
//               become run tokens {1, len-1} with 1 <= len <= MAX_RUN.
//               Runs never span a block boundary (last_i), and the output
//               token register honours valid/ready back-pressure.
// Ports       : clk_i   - clock, rising edge
//               rst_i   - synchronous active-high reset
//               data_i  - input word          (DATA_W)
//               last_i  - final word of block
//               vld_i   - input valid
//               rdy_o   - input ready (independent of vld_i / data_i)
//               data_o  - output token        (DATA_W+1)
//               last_o  - final token of block
//               vld_o   - output valid
//               rdy_i   - output ready
// Revision    : 1.0 - initial release
// ============================================================================
module ebpc_zrle_stream_encoder #(
    parameter int DATA_W  = 8,
    parameter int MAX_RUN = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              vld_i,
    output logic              rdy_o,
    output logic [DATA_W:0]   data_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i
);

    // Counter holds (zeros pending - 1); it never exceeds MAX_RUN-2.
    localparam int RUN_W = $clog2(MAX_RUN);

    localparam logic [RUN_W-1:0]  c_CNT_SAT = RUN_W'(MAX_RUN - 2);
    localparam logic [RUN_W-1:0]  c_CNT_ONE = RUN_W'(1);
    localparam logic [DATA_W-1:0] c_PAY_ONE = DATA_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [RUN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_last_q, hold_last_d;
    logic [DATA_W:0]     data_q, data_d;
    logic                last_q, last_d;
    logic                vld_q, vld_d;

    logic                w_slot_free;
    logic                w_accept;
    logic                w_zero;

    // The output slot can take a new token when it is empty or being drained.
    assign w_slot_free = !vld_q || rdy_i;
    assign rdy_o       = w_slot_free && (state_q != ST_FLUSH);
    assign w_accept    = vld_i && rdy_o;
    assign w_zero      = (data_i == '0);

    assign data_o = data_q;
    assign last_o = last_q;
    assign vld_o  = vld_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        data_d      = data_q;
        last_d      = last_q;
        vld_d       = vld_q;

        // A consumed token empties the slot unless a new one is loaded below.
        if (w_slot_free) begin
            vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_zero) begin
                        vld_d  = 1'b1;
                        data_d = {1'b0, data_i};
                        last_d = last_i;
                    end else if (last_i) begin
                        // Lone zero closing a block: run of length 1.
                        vld_d  = 1'b1;
                        data_d = {1'b1, {DATA_W{1'b0}}};
                        last_d = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (w_accept) begin
                    if (w_zero) begin
                        if (last_i || (cnt_q == c_CNT_SAT)) begin
                            // This zero completes the run: len = cnt+2.
                            vld_d   = 1'b1;
                            data_d  = {1'b1, DATA_W'(cnt_q) + c_PAY_ONE};
                            last_d  = last_i;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + c_CNT_ONE;
                        end
                    end else begin
                        // Close the run now (len = cnt+1); the literal that
                        // broke it waits one cycle in the hold register.
                        vld_d       = 1'b1;
                        data_d      = {1'b1, DATA_W'(cnt_q)};
                        last_d      = 1'b0;
                        hold_d      = data_i;
                        hold_last_d = last_i;
                        state_d     = ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                if (w_slot_free) begin
                    vld_d   = 1'b1;
                    data_d  = {1'b0, hold_q};
                    last_d  = hold_last_q;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            data_q      <= data_d;
            last_q      <= last_d;
            vld_q       <= vld_d;
        end
    end

endmodule
`default_nettype wire
